// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and types: NOP encoding, reset PC, RV32I opcodes
// and the {pc, instr} record carried from fetch to decode.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef enum logic [6:0] {
        OPC_OP_IMM = 7'h13,
        OPC_LOAD   = 7'h03,
        OPC_STORE  = 7'h23,
        OPC_BRANCH = 7'h63,
        OPC_AUIPC  = 7'h17,
        OPC_JAL    = 7'h6F,
        OPC_JALR   = 7'h67
    } opcode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; a pop frees a slot for a
// push in the same cycle even when full. Flush empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               data_i,
    output fetch_entry_t               data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           do_pop, do_push;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_pop)  rptr_d = rptr_q + PW'(1);
            if (do_push) wptr_d = wptr_q + PW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues credit-limited word reads, tags
// returned words with their PCs and buffers them for decode; redirects flush.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [6:0]  id_opcode_o
);

    localparam int unsigned CW  = $clog2(2 * FIFO_DEPTH + 1);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW  = $clog2(FIFO_DEPTH);

    logic [31:0]    pc_q, pc_d;
    logic [CW-1:0]  pend_q, pend_d;
    logic [CW-1:0]  disc_q, disc_d;
    logic [TW-1:0]  tag_wptr_q, tag_wptr_d;
    logic [TW-1:0]  tag_rptr_q, tag_rptr_d;
    logic [31:0]    tag_q [FIFO_DEPTH];

    logic           gnt_acc, disc_hit, push, pop;
    logic [FCW-1:0] fifo_count;
    logic           fifo_empty, fifo_full_unused;
    fetch_entry_t   fifo_in, fifo_head;
    logic           unused_redir_lsbs;

    assign unused_redir_lsbs = ^redirect_pc_i[1:0];

    // Credits cover both FIFO space for live responses and the discard counter,
    // so a response can always be accepted without back-pressure on memory.
    assign imem_req_o  = !reset
                      && ((pend_q + CW'(fifo_count)) < CW'(FIFO_DEPTH))
                      && ((pend_q + disc_q) < CW'(2 * FIFO_DEPTH));
    assign imem_addr_o = pc_q;

    assign gnt_acc  = imem_req_o && imem_gnt_i;
    assign disc_hit = imem_rvalid_i && (disc_q != '0);
    assign push     = imem_rvalid_i && !disc_hit && !redirect_i;
    assign pop      = id_valid_o && id_ready_i && !redirect_i;

    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        disc_d     = disc_q;
        tag_wptr_d = tag_wptr_q;
        tag_rptr_d = tag_rptr_q;
        if (redirect_i) begin
            // Every outstanding request becomes a discard, minus any response
            // landing this very cycle (stale or already-counted, it is dropped).
            disc_d     = disc_q + pend_q + CW'(gnt_acc) - CW'(imem_rvalid_i);
            pend_d     = '0;
            tag_wptr_d = '0;
            tag_rptr_d = '0;
            pc_d       = {redirect_pc_i[31:2], 2'b00};
        end else begin
            if (gnt_acc) begin
                pc_d       = pc_q + 32'd4;
                tag_wptr_d = tag_wptr_q + TW'(1);
            end
            if (push) tag_rptr_d = tag_rptr_q + TW'(1);
            pend_d = pend_q + CW'(gnt_acc) - CW'(push);
            disc_d = disc_q - CW'(disc_hit);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            disc_q     <= '0;
            tag_wptr_q <= '0;
            tag_rptr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            disc_q     <= disc_d;
            tag_wptr_q <= tag_wptr_d;
            tag_rptr_q <= tag_rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_acc && !redirect_i) tag_q[tag_wptr_q] <= pc_q;
    end

    assign fifo_in = '{pc: tag_q[tag_rptr_q], instr: imem_rdata_i};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .data_i  (fifo_in),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full_unused)
    );

    assign id_valid_o  = !fifo_empty;
    assign id_instr_o  = id_valid_o ? fifo_head.instr : NOP_INSTR;
    assign id_pc_o     = id_valid_o ? fifo_head.pc : '0;
    assign id_opcode_o = opcode_of(id_instr_o);

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the RV32I core: owns the PC, issues word reads to instruction memory, buffers returned words with their PCs, and presents them to decode.
- Decode uses id_instr_o to build the immediate and id_opcode_o as the immediate unit's opcode selector.
- Supports back-pressure from decode and taken-branch/jump redirects from execute, with flush of in-flight fetches.

Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset.
- FIFO_DEPTH, 2, number of {pc, instr} buffer entries; power of two, ≥2.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req_o  output  1  fetch request valid.
- imem_addr_o  output  32  word-aligned fetch address; bits [1:0] always 00.
- imem_gnt_i  input  1  memory accepts the request this cycle.
- imem_rvalid_i  input  1  read data valid; responses return in order, ≥1 cycle after grant.
- imem_rdata_i  input  32  instruction word.
- redirect_i  input  1  taken branch/jump from execute.
- redirect_pc_i  input  32  new PC; bits [1:0] ignored and treated as 00.
- id_valid_o  output  1  instruction available to decode.
- id_ready_i  input  1  decode accepts; a transfer occurs when id_valid_o && id_ready_i.
- id_instr_o  output  32  instruction word.
- id_pc_o  output  32  PC of id_instr_o.
- id_opcode_o  output  7  equals id_instr_o[6:0].

Behaviour:
- Reset (async assert, sync release) values:
  - pc = RESET_PC, FIFO empty, all counters 0.
  - imem_req_o = 0, imem_addr_o = RESET_PC, id_valid_o = 0.
  - id_instr_o = 32'h0000_0013 (NOP), id_opcode_o = 7'h13, id_pc_o = 0.
- Reset asserted mid-operation discards all in-flight requests and buffer contents immediately. Responses arriving after reset release are discarded only if granted before reset; the bench drives the memory model idle during reset.
- Request issue:
  - imem_req_o = 1 iff (pend_cnt + fifo_count) < FIFO_DEPTH and (pend_cnt + disc_cnt) < 2*FIFO_DEPTH.
  - This credit scheme guarantees every valid response has a FIFO slot; no response is ever dropped for lack of space.
  - imem_addr_o = pc. On a grant, pc <= pc + 4 (32-bit wrap, 0xFFFF_FFFC -> 0) and pend_cnt increments.
  - While imem_req_o = 1 and not granted, the address is held stable, except on redirect.
- Responses:
  - On imem_rvalid_i, if disc_cnt > 0 then disc_cnt decrements and the data is dropped.
  - Otherwise, {pc_tag, imem_rdata_i} is pushed and pend_cnt decrements.
  - pc_tag is taken from a PC-tag queue written at grant; it is FIFO_DEPTH deep and shares the counters.
- Decode output:
  - id_valid_o = FIFO not empty; fields come from the FIFO head.
  - With no bypass, id_valid_o rises the cycle after the rvalid that fills an empty FIFO.
  - Minimum latency is redirect/reset release -> req (same cycle) -> gnt -> rvalid (+1) -> id_valid_o (+1).
  - When the FIFO is empty, outputs show NOP with id_pc_o = 0.
  - A pop and a push in the same cycle are allowed, including when the FIFO is full: pop first, then write.
- Redirect (highest priority):
  - In the redirect_i cycle, the FIFO is flushed and any pop that cycle is ignored.
  - disc_cnt <= disc_cnt + pend_cnt + (imem_gnt_i ? 1 : 0) - (rvalid consumed by discard ? 1 : 0).
  - pend_cnt <= 0, pc <= {redirect_pc_i[31:2], 2'b00}.
  - A response arriving in the redirect cycle is discarded.
  - A request granted in the redirect cycle is counted as discard.
  - The next cycle, imem_addr_o = new pc and id_valid_o = 0.
- A redirect during an ungranted request withdraws it; no grant-obligation protocol is assumed.
- Back-to-back redirects are each honoured and the last one wins. disc_cnt accumulates and saturation is impossible because of the issue cap.
- Counter widths: $clog2(2*FIFO_DEPTH+1).

Decomposition:
- Package fetch_pkg: NOP_INSTR = 32'h0000_0013, DEFAULT_RESET_PC, opcode constants (7'h13, 7'h03, 7'h23, 7'h63, 7'h17, 7'h6F, 7'h67) shared with decode and the immediate unit.
- Sub-module fetch_fifo: synchronous FIFO of {pc[31:0], instr[31:0]} with push, pop, flush, count, empty and full; async active-high reset.

Test Plan:
- Reset release, memory grants every cycle with 1-cycle rvalid, decode always ready:
  - Required: id_pc_o sequence 0x0040_0000, 0x0040_0004, 0x0040_0008.
  - Required: first id_valid_o exactly 2 cycles after the first grant.
  - Required: id_opcode_o matches rdata[6:0].
- id_ready_i = 0 for 10 cycles:
  - Required: at most FIFO_DEPTH grants occur, then imem_req_o = 0.
  - Required: the FIFO holds 2 entries; on ready, they drain in order with no loss or duplication.
- Two requests in flight and redirect_i with redirect_pc_i = 0x0040_0103:
  - Required: both old responses are dropped.
  - Required: next imem_addr_o = 0x0040_0100, and the first id_pc_o after it is 0x0040_0100.
- Redirect in the same cycle as grant and rvalid:
  - Required: the granted request is counted as discard and the rvalid data is dropped.
  - Required: no stale instruction ever reaches decode.
- pc = 0xFFFF_FFFC granted:
  - Required: the next imem_addr_o is 0x0000_0000.
- Async reset mid-stream with FIFO full:
  - Required: id_valid_o = 0 and imem_req_o = 0 in the same cycle, without waiting for a clock edge.
  - Required: restart at RESET_PC.
